// File: rtl/sprite_draw_scheduler_pkg.sv
// sprite_draw_scheduler_pkg: screen bounds, FSM encoding and default erase colour
package sprite_draw_scheduler_pkg;
  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [6:0] SCREEN_H = 7'd120;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_DRAW = 2'd1;
  localparam state_t S_DONE = 2'd2;
  localparam logic [2:0] DEF_BG_COLOUR = 3'b000;
endpackage

// File: rtl/sprite_draw_scheduler_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from the pointer with wrap
module rr_arbiter
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_pointer,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);
  logic [IW:0] w_s;
  always_comb begin
    o_idx = '0;
    w_s = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_s = {1'b0, i_pointer} + (IW+1)'(k);
      w_s = (w_s >= (IW+1)'(N_REQ)) ? w_s - (IW+1)'(N_REQ) : w_s;
      o_idx = i_req[w_s[IW-1:0]] ? w_s[IW-1:0] : o_idx;
    end
    o_any = |i_req;
    o_gnt = o_any ? N_REQ'(1) << o_idx : '0;
  end
endmodule

// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler: round-robin sharing of the VGA pixel port, drawing one SIZE x SIZE box per grant
module sprite_draw_scheduler
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int SIZE = 4,
  parameter logic [2:0] BG_COLOUR = DEF_BG_COLOUR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] erase,
  input  logic [N_REQ*8-1:0] x_in,
  input  logic [N_REQ*7-1:0] y_in,
  input  logic [N_REQ*3-1:0] colour_in,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic [7:0]       vga_x,
  output logic [6:0]       vga_y,
  output logic [2:0]       vga_colour,
  output logic             vga_plot
);
  localparam int IW = $clog2(N_REQ);
  localparam int LW = $clog2(SIZE);
  localparam int CW = 2 * LW;
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_idx, w_idx;
  logic [N_REQ-1:0] r_grant, w_gnt;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_bx, w_sx, w_px;
  logic [6:0] r_by, w_sy, w_py;
  logic [2:0] r_col, w_sc;
  logic r_erase, w_se, w_any, w_draw;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req(req),
    .i_pointer(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  always_comb begin
    w_sx = '0;
    w_sy = '0;
    w_sc = '0;
    w_se = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sx = (w_idx == IW'(i)) ? x_in[8*i +: 8] : w_sx;
      w_sy = (w_idx == IW'(i)) ? y_in[7*i +: 7] : w_sy;
      w_sc = (w_idx == IW'(i)) ? colour_in[3*i +: 3] : w_sc;
      w_se = (w_idx == IW'(i)) ? erase[i] : w_se;
    end
  end
  always_ff @(posedge clk)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == S_IDLE) ? (w_any ? S_DRAW : S_IDLE) :
             (r_state == S_DRAW) ? (&r_cnt ? S_DONE : S_DRAW) : S_IDLE;
  always_ff @(posedge clk)
    if (reset) begin
      r_ptr <= '0;
      r_idx <= '0;
      r_grant <= '0;
      r_cnt <= '0;
      r_bx <= '0;
      r_by <= '0;
      r_col <= '0;
      r_erase <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_idx <= w_idx;
        r_grant <= w_gnt;
        r_bx <= w_sx;
        r_by <= w_sy;
        r_col <= w_sc;
        r_erase <= w_se;
        r_cnt <= '0;
      end else if (r_state == S_DRAW) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_DONE) r_ptr <= (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
    end
  // Off-screen pixels still take their cycle so box timing never depends on position
  always_comb begin
    w_draw = r_state == S_DRAW;
    w_px = r_bx + 8'(r_cnt[LW-1:0]);
    w_py = r_by + 7'(r_cnt[CW-1:LW]);
    vga_x = w_draw ? w_px : '0;
    vga_y = w_draw ? w_py : '0;
    vga_colour = w_draw ? (r_erase ? BG_COLOUR : r_col) : '0;
    vga_plot = w_draw && (w_px < SCREEN_W) && (w_py < SCREEN_H);
    grant = w_draw ? r_grant : '0;
    done = (r_state == S_DONE) ? r_grant : '0;
    busy = r_state != S_IDLE;
  end
endmodule
